// File: rtl/imem_loader_pkg.sv
// Shared definitions for the serial instruction-memory loader:
// FSM encodings, default framing constants and UART bit-timing helpers.
package imem_loader_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE    = 8'hA5;
  localparam int         DEFAULT_CLKS_PER_BIT = 104;
  localparam int         DEFAULT_ADDR_W       = 4;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Tick index at which the start bit is re-checked (middle of the bit).
  function automatic int midBitTick(input int clksPerBit);
    return (clksPerBit / 2) - 1;
  endfunction

  function automatic int bitCntWidth(input int clksPerBit);
    return (clksPerBit <= 2) ? 1 : $clog2(clksPerBit);
  endfunction

endpackage

// File: rtl/imem_loader_uart_rx.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchroniser, mid-bit start check,
// LSB-first shift register; strobes o_valid or o_frame_err one cycle after the stop sample.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int                CNT_W     = bitCntWidth(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  MID_TICK  = CNT_W'(midBitTick(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       r_sync;
  logic             r_rxPrev;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_tick;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic             r_frameErr;
  logic             w_rx;

  assign w_rx        = r_sync[1];
  assign o_byte      = r_shift;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frameErr;

  // Sync flops reset high so a reset release never looks like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync     <= 2'b11;
      r_rxPrev   <= 1'b1;
      r_state    <= RX_IDLE;
      r_tick     <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_rx};
      r_rxPrev   <= w_rx;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_rxPrev && !w_rx) begin
            r_state <= RX_START;
            r_tick  <= '0;
          end
        end
        RX_START: begin
          if (r_tick == MID_TICK) begin
            r_tick   <= '0;
            r_bitIdx <= '0;
            r_state  <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_tick <= r_tick + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_tick == LAST_TICK) begin
            r_tick  <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bitIdx == 3'd7) begin
              r_state <= RX_STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end else begin
            r_tick <= r_tick + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_tick == LAST_TICK) begin
            r_tick     <= '0;
            r_state    <= RX_IDLE;
            r_valid    <= w_rx;
            r_frameErr <= ~w_rx;
          end else begin
            r_tick <= r_tick + CNT_W'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: UART program loader filling instruction memory from address 0, holding the CPU until done.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int         ADDR_W       = DEFAULT_ADDR_W,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W     = ADDR_W + 1;
  localparam int MAX_WORDS = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t ST_FINAL = ST_CHECK;
`else
  localparam loader_state_t ST_FINAL = ST_DONE;
`endif

  logic [7:0]        w_byte;
  logic              w_byteValid;
  logic              w_frameErr;
  logic              w_isSync;
  logic              w_countTooBig;
  logic              w_lastWord;
  loader_state_t     w_nextState;

  loader_state_t     r_state;
  logic [CNT_W-1:0]  r_wordsLeft;
  logic [1:0]        r_byteIdx;
  logic [23:0]       r_word;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpuHold;
  logic              r_loadDone;
  logic              r_loadErr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_rx        (uart_rx),
    .o_byte      (w_byte),
    .o_valid     (w_byteValid),
    .o_frame_err (w_frameErr)
  );

  assign w_isSync      = (w_byte == SYNC_BYTE);
  assign w_countTooBig = ({24'd0, w_byte} > 32'(MAX_WORDS));
  assign w_lastWord    = (r_wordsLeft == CNT_W'(1));

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_cpuHold;
  assign load_done  = r_loadDone;
  assign load_err   = r_loadErr;

  // Framing errors abort any frame in progress but are harmless while hunting or loaded.
  always_comb begin
    w_nextState = r_state;
    if (w_frameErr) begin
      if (r_state != ST_HUNT && r_state != ST_DONE) begin
        w_nextState = ST_ERR;
      end
    end else if (w_byteValid) begin
      case (r_state)
        ST_HUNT:  if (w_isSync) w_nextState = ST_COUNT;
        ST_COUNT: begin
          if (w_countTooBig) begin
            w_nextState = ST_ERR;
          end else if (w_byte == 8'd0) begin
            w_nextState = ST_FINAL;
          end else begin
            w_nextState = ST_DATA;
          end
        end
        ST_DATA:  if (r_byteIdx == 2'd3 && w_lastWord) w_nextState = ST_FINAL;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: w_nextState = (w_byte == r_sum) ? ST_DONE : ST_ERR;
`endif
        ST_DONE:  if (w_isSync) w_nextState = ST_COUNT;
        ST_ERR:   if (w_isSync) w_nextState = ST_COUNT;
        default:  w_nextState = ST_HUNT;
      endcase
    end
  end

  // Status flags are registered straight from the next state so they move together with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_HUNT;
      r_wordsLeft <= '0;
      r_byteIdx   <= '0;
      r_word      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpuHold   <= 1'b1;
      r_loadDone  <= 1'b0;
      r_loadErr   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_state    <= w_nextState;
      r_cpuHold  <= (w_nextState != ST_DONE);
      r_loadDone <= (w_nextState == ST_DONE);
      r_loadErr  <= (w_nextState == ST_ERR);
      r_we       <= 1'b0;

      // Advance only after a non-final write so the address never wraps past the top word.
      if (r_we && r_state == ST_DATA) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      if (w_byteValid && !w_frameErr) begin
        case (r_state)
          ST_COUNT: begin
            r_wordsLeft <= w_byte[CNT_W-1:0];
            r_byteIdx   <= '0;
            r_addr      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum       <= w_byte;
`endif
          end
          ST_DATA: begin
            r_byteIdx <= r_byteIdx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum     <= r_sum + w_byte;
`endif
            case (r_byteIdx)
              2'd0: r_word[7:0]   <= w_byte;
              2'd1: r_word[15:8]  <= w_byte;
              2'd2: r_word[23:16] <= w_byte;
              default: begin
                r_we        <= 1'b1;
                r_wdata     <= {w_byte, r_word};
                r_wordsLeft <= r_wordsLeft - CNT_W'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: serial frames driven bit by bit, checked against a byte-level model.
module tb_imem_loader;

  localparam int         CPB  = 4;
  localparam int         AW   = 4;
  localparam logic [7:0] SYNC = 8'hA5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int P_HUNT = 0, P_COUNT = 1, P_DATA = 2, P_CHECK = 3, P_DONE = 4, P_ERR = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  imem_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW),
    .SYNC_BYTE    (SYNC)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t  expQ[$];
  wr_t  actQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;
  int   weLong = 0;
  int   holdSkew = 0;
  int   rxStrobes = 0;
  logic prevWe = 1'b0;

  int          mPhase = P_HUNT;
  int          mWords = 0;
  int          mBytes = 0;
  logic [7:0]  mSum = 8'd0;
  logic [31:0] mWord = 32'd0;

  // Write log plus pulse-width / flag-coherence monitors.
  always @(negedge CLK) begin
    if (!RST) begin
      if (imem_we) actQ.push_back(wr_t'({imem_addr, imem_wdata}));
      if (imem_we && prevWe) weLong++;
      if (cpu_hold == load_done) holdSkew++;
    end
    prevWe = imem_we;
  end

  always @(posedge CLK) if (dut.w_byteValid) rxStrobes++;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void modelReset();
    mPhase = P_HUNT;
    mWords = 0;
    mBytes = 0;
    mSum   = 8'd0;
    expQ.delete();
  endfunction

  // Byte-level behaviour of the loader as described by the frame rules.
  function automatic void modelByte(input logic [7:0] b, input bit ferr);
    if (ferr) begin
      if (mPhase != P_HUNT && mPhase != P_DONE) mPhase = P_ERR;
      return;
    end
    case (mPhase)
      P_HUNT: if (b == SYNC) mPhase = P_COUNT;
      P_COUNT: begin
        if (int'(b) > (1 << AW)) begin
          mPhase = P_ERR;
        end else begin
          mWords = int'(b);
          mBytes = 0;
          mSum   = b;
          mPhase = (b == 8'd0) ? (CHK_EN ? P_CHECK : P_DONE) : P_DATA;
        end
      end
      P_DATA: begin
        mSum = mSum + b;
        mWord[8*(mBytes % 4) +: 8] = b;
        mBytes++;
        if (mBytes % 4 == 0) begin
          expQ.push_back(wr_t'({AW'(mBytes / 4 - 1), mWord}));
          if (mBytes == 4 * mWords) mPhase = CHK_EN ? P_CHECK : P_DONE;
        end
      end
      P_CHECK: mPhase = (b == mSum) ? P_DONE : P_ERR;
      default: if (b == SYNC) mPhase = P_COUNT;
    endcase
  endfunction

  function automatic logic [2:0] expFlags();
    return {mPhase != P_DONE, mPhase == P_DONE, mPhase == P_ERR};
  endfunction

  function automatic logic [7:0] sum8(input logic [7:0] q[$]);
    logic [7:0] s = 8'd0;
    for (int i = 1; i < q.size(); i++) s = s + q[i];
    return s;
  endfunction

  task automatic sendByte(input logic [7:0] b, input bit badStop);
    logic [9:0] bits;
    bits = {~badStop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (CPB) @(negedge CLK);
    end
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    modelByte(b, badStop);
  endtask

  task automatic sendBytes(input logic [7:0] q[$]);
    foreach (q[i]) sendByte(q[i], 1'b0);
  endtask

  task automatic buildFrame(input logic [7:0] countByte, input int nDataBytes,
                            input bit corrupt, output logic [7:0] q[$]);
    logic [7:0] cs;
    q = {};
    q.push_back(SYNC);
    q.push_back(countByte);
    for (int i = 0; i < nDataBytes; i++) q.push_back(8'($urandom_range(0, 255)));
    cs = sum8(q);
    if (CHK_EN) q.push_back(corrupt ? ~cs : cs);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    nCompared++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b0, AW'(0), 32'd0}) begin
      nMismatched++;
      $display("[TB] FAIL reset_write_port: got we=%b addr=%0d data=%h want 0/0/0", imem_we, imem_addr, imem_wdata);
    end
    nCompared++;
    if ({cpu_hold, load_done, load_err} !== 3'b100) begin
      nMismatched++;
      $display("[TB] FAIL reset_flags: got %b want 100", {cpu_hold, load_done, load_err});
    end
    RST = 1'b0;
    repeat (2 * CPB) @(negedge CLK);
  endtask

  task automatic test_good_frame();
    logic [7:0] q[$];
    actQ.delete(); expQ.delete();
    weLong = 0; holdSkew = 0;
    q = {SYNC, 8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00};
    if (CHK_EN) q.push_back(sum8(q));
    sendBytes(q);
    nCompared++;
    if (actQ.size() != 2) begin
      nMismatched++;
      $display("[TB] FAIL good_frame_count: got %0d writes want 2", actQ.size());
    end
    if (actQ.size() == 2) begin
      nCompared++;
      if (actQ[0] !== wr_t'({AW'(0), 32'h00500093}) || actQ[1] !== wr_t'({AW'(1), 32'h00300113})) begin
        nMismatched++;
        $display("[TB] FAIL good_frame_words: got %h@%0d %h@%0d want 00500093@0 00300113@1",
                 actQ[0].data, actQ[0].addr, actQ[1].data, actQ[1].addr);
      end
    end
    nCompared++;
    if ({cpu_hold, load_done, load_err} !== 3'b010) begin
      nMismatched++;
      $display("[TB] FAIL good_frame_flags: got %b want 010", {cpu_hold, load_done, load_err});
    end
    nCompared++;
    if (weLong !== 0 || holdSkew !== 0) begin
      nMismatched++;
      $display("[TB] FAIL good_frame_timing: got weLong=%0d holdSkew=%0d want 0/0", weLong, holdSkew);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] q[$];
    actQ.delete(); expQ.delete();
    q = {SYNC, 8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h30, 8'h00};
    if (CHK_EN) q.push_back(8'h00);
    sendBytes(q);
    nCompared++;
    if ({cpu_hold, load_done, load_err} !== expFlags()) begin
      nMismatched++;
      $display("[TB] FAIL bad_checksum_flags: got %b want %b", {cpu_hold, load_done, load_err}, expFlags());
    end
    nCompared++;
    if (actQ.size() != expQ.size()) begin
      nMismatched++;
      $display("[TB] FAIL bad_checksum_writes: got %0d want %0d", actQ.size(), expQ.size());
    end
  endtask

  task automatic test_oversize();
    actQ.delete(); expQ.delete();
    sendBytes({SYNC, 8'h11});
    nCompared++;
    if ({cpu_hold, load_done, load_err} !== 3'b101) begin
      nMismatched++;
      $display("[TB] FAIL oversize_flags: got %b want 101", {cpu_hold, load_done, load_err});
    end
    nCompared++;
    if (actQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL oversize_writes: got %0d want 0", actQ.size());
    end
  endtask

  task automatic test_framing_recovery();
    logic [7:0] q[$];
    actQ.delete(); expQ.delete();
    sendBytes({SYNC, 8'h02, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))});
    sendByte(8'h3C, 1'b1);
    nCompared++;
    if ({cpu_hold, load_done, load_err} !== 3'b101) begin
      nMismatched++;
      $display("[TB] FAIL framing_err_flags: got %b want 101", {cpu_hold, load_done, load_err});
    end
    buildFrame(8'h01, 4, 1'b0, q);
    sendBytes(q);
    nCompared++;
    if ({cpu_hold, load_done, load_err} !== expFlags()) begin
      nMismatched++;
      $display("[TB] FAIL framing_recover_flags: got %b want %b", {cpu_hold, load_done, load_err}, expFlags());
    end
    nCompared++;
    if (actQ.size() != 1 || expQ.size() != 1 || actQ[0] !== expQ[0]) begin
      nMismatched++;
      $display("[TB] FAIL framing_recover_write: got %0d writes first=%h want 1 write %h",
               actQ.size(), (actQ.size() > 0) ? actQ[0] : wr_t'(0), (expQ.size() > 0) ? expQ[0] : wr_t'(0));
    end
  endtask

  task automatic test_glitch();
    int s0;
    logic [2:0] f0;
    actQ.delete();
    s0 = rxStrobes;
    f0 = {cpu_hold, load_done, load_err};
    uart_rx = 1'b0;
    repeat (2) @(negedge CLK);
    uart_rx = 1'b1;
    repeat (12 * CPB) @(negedge CLK);
    nCompared++;
    if (rxStrobes !== s0) begin
      nMismatched++;
      $display("[TB] FAIL glitch_strobe: got %0d strobes want %0d", rxStrobes, s0);
    end
    nCompared++;
    if ({cpu_hold, load_done, load_err} !== expFlags() || actQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL glitch_state: got %b (was %b) writes=%0d want %b writes=0",
               {cpu_hold, load_done, load_err}, f0, actQ.size(), expFlags());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] q[$];
    actQ.delete(); expQ.delete();
    sendBytes({SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
    uart_rx = 1'b0;
    repeat (6) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    nCompared++;
    if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err} !==
        {1'b0, AW'(0), 32'd0, 3'b100}) begin
      nMismatched++;
      $display("[TB] FAIL midframe_reset: got addr=%0d data=%h flags=%b want 0/00000000/100",
               imem_addr, imem_wdata, {cpu_hold, load_done, load_err});
    end
    uart_rx = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    modelReset();
    actQ.delete();
    repeat (2 * CPB) @(negedge CLK);
    buildFrame(8'h02, 8, 1'b0, q);
    sendBytes(q);
    nCompared++;
    if (actQ.size() != expQ.size() || {cpu_hold, load_done, load_err} !== expFlags()) begin
      nMismatched++;
      $display("[TB] FAIL midframe_reload: got %0d writes flags=%b want %0d flags=%b",
               actQ.size(), {cpu_hold, load_done, load_err}, expQ.size(), expFlags());
    end
    for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
      nCompared++;
      if (actQ[i] !== expQ[i]) begin
        nMismatched++;
        $display("[TB] FAIL midframe_word[%0d]: got %h@%0d want %h@%0d",
                 i, actQ[i].data, actQ[i].addr, expQ[i].data, expQ[i].addr);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] q[$];
    int counts[6];
    counts = '{16, 0, 3, 200, 2, 5};
    for (int f = 0; f < 6; f++) begin
      actQ.delete(); expQ.delete();
      if (f == 2) counts[f] = $urandom_range(1, 6);
      if (f == 3) counts[f] = $urandom_range(17, 255);
      buildFrame(8'(counts[f]), (counts[f] > 16) ? 4 : 4 * counts[f], (f == 4), q);
      sendBytes(q);
      nCompared++;
      if (actQ.size() != expQ.size() || {cpu_hold, load_done, load_err} !== expFlags()) begin
        nMismatched++;
        $display("[TB] FAIL random_frame%0d: got %0d writes flags=%b want %0d flags=%b",
                 f, actQ.size(), {cpu_hold, load_done, load_err}, expQ.size(), expFlags());
      end
      for (int i = 0; i < actQ.size() && i < expQ.size(); i++) begin
        nCompared++;
        if (actQ[i] !== expQ[i]) begin
          nMismatched++;
          $display("[TB] FAIL random_frame%0d_word[%0d]: got %h@%0d want %h@%0d",
                   f, i, actQ[i].data, actQ[i].addr, expQ[i].data, expQ[i].addr);
        end
      end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_oversize();
    test_framing_recovery();
    test_glitch();
    test_reset_midframe();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
